// File: rtl/tile_probe_scheduler_if.sv
// Tile-map read port shared by the probe scheduler and the map memory.
// Read data is registered: map_data is valid the cycle after map_rd_en.
interface tile_probe_scheduler_if;
  logic       map_rd_en;
  logic [3:0] map_row;
  logic [4:0] map_col;
  logic [2:0] map_data;

  modport master (
    output map_rd_en,
    output map_row,
    output map_col,
    input  map_data
  );

  modport slave (
    input  map_rd_en,
    input  map_row,
    input  map_col,
    output map_data
  );
endinterface

// File: rtl/tile_probe_scheduler.sv
// Per-frame collision probe sequencer: walks a fixed list of tile-map reads around the
// player's bottom corners and produces in_air, gravity_next and hit_ground.
module tile_probe_scheduler #(
  parameter int unsigned SELF_W     = 26,
  parameter int unsigned SNAP_MAX   = 5,
  parameter int unsigned V_TERMINAL = 6,
  parameter int unsigned MAP_ROWS   = 15,
  parameter int unsigned MAP_COLS   = 20,
  parameter logic [2:0]  SOLID      = 3'b111
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic [9:0]                    self_x,
  input  logic [9:0]                    self_y,
  input  logic [3:0]                    gravity,
  input  logic                          rend_req,
  input  logic [3:0]                    rend_row,
  input  logic [4:0]                    rend_col,
  output logic                          rend_gnt,
  tile_probe_scheduler_if.master        map,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output logic                          in_air,
  output logic [3:0]                    gravity_next,
  output logic                          hit_ground
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [2:0] {PrP0, PrP1, PrSnapL, PrSnapR, PrHg} probe_e;

  state_e     state_q, state_d;
  probe_e     probe_q, probe_d;
  logic [9:0] x_q, y_q;
  logic [3:0] g_q;
  logic [3:0] d_q, d_d;
  logic       air_q, air_d;
  logic [3:0] gsel_q, gsel_d;
  logic       in_air_q, in_air_d;
  logic [3:0] gnext_q, gnext_d;
  logic       hit_q, hit_d;
  logic       overrun_q;

  logic [9:0] left_x, fall_y, ya, xa;
  logic [4:0] row, col;
  logic       in_range;
  logic       eval, solid;
  logic [4:0] g_inc;
  logic [3:0] g_clamp;

  // Probe address for the current step; all arithmetic wraps at 10 bits.
  always_comb begin
    left_x = x_q - 10'(SELF_W);
    fall_y = y_q + 10'(g_q) + 10'd1;
    ya     = y_q + 10'd1;
    xa     = x_q;
    unique case (probe_q)
      PrP0:    begin ya = fall_y;           xa = x_q;    end
      PrP1:    begin ya = fall_y;           xa = left_x; end
      PrSnapL: begin ya = y_q + 10'(d_q);   xa = left_x; end
      PrSnapR: begin ya = y_q + 10'(d_q);   xa = x_q;    end
      default: begin ya = y_q + 10'd1;      xa = x_q;    end
    endcase
    row      = 5'(ya >> 5);
    col      = 5'(xa >> 5);
    in_range = (row < 5'(MAP_ROWS)) && (col < 5'(MAP_COLS));
  end

  always_comb begin
    g_inc   = {1'b0, g_q} + 5'd1;
    g_clamp = (g_inc > 5'(V_TERMINAL)) ? 4'(V_TERMINAL) : g_inc[3:0];
  end

  // Renderer always owns the port when it asks; otherwise only in-range probes read.
  always_comb begin
    rend_gnt      = rend_req;
    map.map_rd_en = rend_req | ((state_q == StIssue) && in_range);
    map.map_row   = rend_req ? rend_row : row[3:0];
    map.map_col   = rend_req ? rend_col : col;
  end

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    d_d      = d_q;
    air_d    = air_q;
    gsel_d   = gsel_q;
    in_air_d = in_air_q;
    gnext_d  = gnext_q;
    hit_d    = hit_q;
    eval     = 1'b0;
    solid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StIssue;
          probe_d = PrP0;
          d_d     = 4'(SNAP_MAX);
          air_d   = 1'b0;
          gsel_d  = 4'd0;
        end
      end
      StIssue: begin
        if (!rend_req) begin
          if (in_range) begin
            state_d = StWait;
          end else begin
            // Off-map tiles count as solid and resolve without a read.
            eval  = 1'b1;
            solid = 1'b1;
          end
        end
      end
      StWait: begin
        state_d = StIssue;
        eval    = 1'b1;
        solid   = (map.map_data == SOLID);
      end
      default: state_d = StIdle;
    endcase

    if (eval) begin
      unique case (probe_q)
        PrP0, PrP1: begin
          if (solid) begin
            probe_d = PrSnapL;
            d_d     = 4'(SNAP_MAX);
          end else if (probe_q == PrP0) begin
            probe_d = PrP1;
          end else begin
            air_d   = 1'b1;
            probe_d = PrHg;
          end
        end
        PrSnapL, PrSnapR: begin
          if (!solid && probe_q == PrSnapL) begin
            probe_d = PrSnapR;
          end else if (!solid) begin
            gsel_d  = d_q;
            probe_d = PrHg;
          end else if (d_q == 4'd1) begin
            probe_d = PrHg;
          end else begin
            d_d     = d_q - 4'd1;
            probe_d = PrSnapL;
          end
        end
        default: begin
          state_d  = StDone;
          in_air_d = air_q;
          gnext_d  = air_q ? g_clamp : gsel_q;
          hit_d    = solid;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      probe_q   <= PrP0;
      x_q       <= '0;
      y_q       <= '0;
      g_q       <= '0;
      d_q       <= '0;
      air_q     <= 1'b0;
      gsel_q    <= '0;
      in_air_q  <= 1'b0;
      gnext_q   <= '0;
      hit_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      probe_q   <= probe_d;
      d_q       <= d_d;
      air_q     <= air_d;
      gsel_q    <= gsel_d;
      in_air_q  <= in_air_d;
      gnext_q   <= gnext_d;
      hit_q     <= hit_d;
      overrun_q <= frame_tick && (state_q != StIdle);
      if (state_q == StIdle && frame_tick) begin
        x_q <= self_x;
        y_q <= self_y;
        g_q <= gravity;
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign overrun      = overrun_q;
  assign in_air       = in_air_q;
  assign gravity_next = gnext_q;
  assign hit_ground   = hit_q;

endmodule

// File: tb/tb_tile_probe_scheduler.sv
// Directed bench for tile_probe_scheduler: fixed tile map, hand-computed latencies and results.
module tb_tile_probe_scheduler;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] self_x = '0;
  logic [9:0] self_y = '0;
  logic [3:0] gravity = '0;
  logic       rend_req = 1'b0;
  logic [3:0] rend_row = 4'd12;
  logic [4:0] rend_col = 5'd7;
  logic       rend_gnt, busy, done, overrun, in_air, hit_ground;
  logic [3:0] gravity_next;

  int checks = 0;
  int errors = 0;

  tile_probe_scheduler_if map_if ();

  tile_probe_scheduler dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .self_x       (self_x),
    .self_y       (self_y),
    .gravity      (gravity),
    .rend_req     (rend_req),
    .rend_row     (rend_row),
    .rend_col     (rend_col),
    .rend_gnt     (rend_gnt),
    .map          (map_if.master),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .in_air       (in_air),
    .gravity_next (gravity_next),
    .hit_ground   (hit_ground)
  );

  always #5 Clk = ~Clk;

  // Map: rows >= 11 solid, row 10 a non-solid code that differs from SOLID in one bit.
  function automatic logic [2:0] tile_code(input logic [3:0] r);
    if (r >= 4'd11) return 3'b111;
    if (r == 4'd10) return 3'b110;
    return 3'b000;
  endfunction

  initial map_if.map_data = 3'b000;
  always @(posedge Clk) begin
    if (map_if.map_rd_en) map_if.map_data <= tile_code(map_if.map_row);
  end

  // Cycle c = interval after the c-th edge following the tick; inputs set at negedge, sampled #1.
  task automatic run_batch(input logic [9:0] x, input logic [9:0] y, input logic [3:0] g,
                           input int rend_lo, input int rend_hi, input int tick2,
                           input int budget, output int done_at, output logic r_air,
                           output logic [3:0] r_g, output logic r_hit, output int ovr_at,
                           output int busy_cnt, output logic mux_ok, output logic col31);
    done_at = -1; ovr_at = -1; busy_cnt = 0; mux_ok = 1'b1; col31 = 1'b0;
    r_air = 1'bx; r_g = 4'hx; r_hit = 1'bx;
    for (int c = 0; c <= budget; c++) begin
      @(negedge Clk);
      frame_tick = (c == 0) || (c == tick2);
      self_x     = (c == 0) ? x : 10'h2aa;
      self_y     = (c == 0) ? y : 10'h155;
      gravity    = (c == 0) ? g : 4'hf;
      rend_req   = (c >= rend_lo) && (c <= rend_hi);
      #1;
      if (busy) busy_cnt++;
      if (overrun && ovr_at < 0) ovr_at = c;
      if (rend_req && !(rend_gnt && map_if.map_rd_en && map_if.map_row == rend_row &&
                        map_if.map_col == rend_col)) mux_ok = 1'b0;
      if (!rend_req && map_if.map_rd_en && map_if.map_col == 5'd31) col31 = 1'b1;
      if (done) begin
        done_at = c; r_air = in_air; r_g = gravity_next; r_hit = hit_ground;
        break;
      end
    end
    @(negedge Clk);
    frame_tick = 1'b0; rend_req = 1'b0;
    #1;
  endtask

  task automatic check_batch(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic [3:0] g, input int rend_lo, input int rend_hi,
                             input int tick2, input int exp_done, input logic exp_air,
                             input logic [3:0] exp_g, input logic exp_hit, input int exp_ovr);
    int done_at, ovr_at, busy_cnt;
    logic r_air, r_hit, mux_ok, col31;
    logic [3:0] r_g;
    run_batch(x, y, g, rend_lo, rend_hi, tick2, 40, done_at, r_air, r_g, r_hit, ovr_at,
              busy_cnt, mux_ok, col31);
    checks++;
    if (done_at !== exp_done) begin
      errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_at, exp_done);
    end
    checks++;
    if ({r_air, r_g, r_hit} !== {exp_air, exp_g, exp_hit}) begin
      errors++;
      $display("FAIL %s results got air=%b g=%0d hit=%b want air=%b g=%0d hit=%b",
               name, r_air, r_g, r_hit, exp_air, exp_g, exp_hit);
    end
    checks++;
    if (busy_cnt !== exp_done) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, exp_done);
    end
    checks++;
    if (ovr_at !== exp_ovr) begin
      errors++; $display("FAIL %s overrun_cycle got %0d want %0d", name, ovr_at, exp_ovr);
    end
    checks++;
    if ({mux_ok, col31} !== 2'b10) begin
      errors++; $display("FAIL %s port_mux got ok=%b col31=%b want ok=1 col31=0",
                         name, mux_ok, col31);
    end
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if ({busy, done, overrun, in_air, gravity_next, hit_ground, map_if.map_rd_en} !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b ovr=%b air=%b g=%0d hit=%b rd=%b want 0",
               busy, done, overrun, in_air, gravity_next, hit_ground, map_if.map_rd_en);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_airborne();
    check_batch("airborne", 10'd30, 10'd33, 4'd0, -1, -1, -1, 7, 1'b1, 4'd1, 1'b0, -1);
  endtask

  task automatic test_snap_fail();
    check_batch("snap_fail", 10'd100, 10'd351, 4'd0, -1, -1, -1, 15, 1'b0, 4'd0, 1'b1, -1);
  endtask

  task automatic test_snap_pass();
    check_batch("snap_pass", 10'd100, 10'd345, 4'd6, -1, -1, -1, 9, 1'b0, 4'd5, 1'b0, -1);
    check_batch("clamp", 10'd100, 10'd340, 4'd6, -1, -1, -1, 7, 1'b1, 4'd6, 1'b0, -1);
  endtask

  task automatic test_out_of_range();
    check_batch("out_of_range", 10'd10, 10'd33, 4'd0, -1, -1, -1, 11, 1'b0, 4'd0, 1'b0, -1);
  endtask

  task automatic test_renderer_overrun();
    check_batch("renderer", 10'd30, 10'd33, 4'd0, 1, 10, 3, 17, 1'b1, 4'd1, 1'b0, 4);
  endtask

  task automatic test_reset_mid_batch();
    logic saw_done = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge Clk);
      frame_tick = (c == 0);
      self_x = 10'd30; self_y = 10'd33; gravity = 4'd0;
      Reset = (c == 4);
      #1;
      if (done) saw_done = 1'b1;
      if (c == 5) begin
        checks++;
        if ({busy, map_if.map_rd_en, in_air, gravity_next, hit_ground, done} !== '0) begin
          errors++;
          $display("FAIL mid_reset got busy=%b rd=%b air=%b g=%0d hit=%b done=%b want 0",
                   busy, map_if.map_rd_en, in_air, gravity_next, hit_ground, done);
        end
      end
    end
    Reset = 1'b0;
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset done_seen got %b want 0", saw_done);
    end
    check_batch("after_reset", 10'd100, 10'd345, 4'd6, -1, -1, -1, 9, 1'b0, 4'd5, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_airborne();
    test_snap_fail();
    test_snap_pass();
    test_out_of_range();
    test_renderer_overrun();
    test_reset_mid_batch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
